// File: rtl/fma_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fma_sched_pkg : op codes, FSM encoding and sign-bit index            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fma_sched_pkg;

   localparam logic [1:0] OP_FMADD  = 2'b00;
   localparam logic [1:0] OP_FMSUB  = 2'b01;
   localparam logic [1:0] OP_FNMSUB = 2'b10;
   localparam logic [1:0] OP_FNMADD = 2'b11;

   localparam int SIGN_BIT = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fma_sched_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at ptr          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int IDXW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDXW-1:0] winner
);

   logic            w_hit;
   int              w_sum;
   logic [IDXW-1:0] w_idx;

   always_comb begin
      grant  = '0;
      winner = '0;
      w_hit  = 1'b0;
      w_sum  = 0;
      w_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = int'(ptr) + k;
         if (w_sum >= NREQ) w_sum = w_sum - NREQ;
         w_idx = IDXW'(w_sum);
         if (!w_hit && req[w_idx]) begin
            w_hit         = 1'b1;
            grant[w_idx]  = 1'b1;
            winner        = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fma_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fma_sched : round-robin scheduler sharing one external FMA unit      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fma_sched
   import fma_sched_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 3,
   parameter int LAT   = 3
) (
   input  logic                  clk,
   input  logic                  RST,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*WIDTH-1:0] req_c,
   input  logic [NREQ*2-1:0]     req_op,
   input  logic [NREQ*2-1:0]     req_rnd,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [1:0]            resp_id,
   output logic [WIDTH-1:0]      resp_data,
   output logic [WIDTH-1:0]      fma_a,
   output logic [WIDTH-1:0]      fma_b,
   output logic [WIDTH-1:0]      fma_c,
   output logic [1:0]            fma_rnd,
   output logic                  fma_en,
   input  logic [WIDTH-1:0]      fma_result
);

   localparam int IDXW = $clog2(NREQ);

   state_t           r_state, w_nextState;
   logic [IDXW-1:0]  r_ptr;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_a, r_b, r_c, r_data;
   logic [1:0]       r_rnd, r_id;
   logic             r_armed;

   logic [NREQ-1:0]  w_grant;
   logic [IDXW-1:0]  w_winner;
   logic             w_accept, w_busy;
   logic [WIDTH-1:0] w_selA, w_selB, w_selC, w_opA, w_opC;
   logic [1:0]       w_selOp, w_selRnd;
   logic             w_negA, w_negC;

   rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
      .req    (req_valid),
      .ptr    (r_ptr),
      .grant  (w_grant),
      .winner (w_winner)
   );

   assign w_selA   = req_a[int'(w_winner)*WIDTH +: WIDTH];
   assign w_selB   = req_b[int'(w_winner)*WIDTH +: WIDTH];
   assign w_selC   = req_c[int'(w_winner)*WIDTH +: WIDTH];
   assign w_selOp  = req_op[int'(w_winner)*2 +: 2];
   assign w_selRnd = req_rnd[int'(w_winner)*2 +: 2];

   // Negation is applied once at accept time so the issued operands stay stable.
   always_comb begin
      w_negA = 1'b0;
      w_negC = 1'b0;
      case (w_selOp)
         OP_FMADD:  begin w_negA = 1'b0; w_negC = 1'b0; end
         OP_FMSUB:  begin w_negA = 1'b0; w_negC = 1'b1; end
         OP_FNMSUB: begin w_negA = 1'b1; w_negC = 1'b0; end
         OP_FNMADD: begin w_negA = 1'b1; w_negC = 1'b1; end
         default:   begin w_negA = 1'b0; w_negC = 1'b0; end
      endcase
      w_opA           = w_selA;
      w_opC           = w_selC;
      w_opA[SIGN_BIT] = w_selA[SIGN_BIT] ^ w_negA;
      w_opC[SIGN_BIT] = w_selC[SIGN_BIT] ^ w_negC;
   end

   assign w_accept = (r_state == IDLE) && r_armed && (|w_grant);

   always_comb begin
      w_nextState = r_state;
      req_ready   = '0;
      fma_en      = 1'b0;
      resp_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_armed) req_ready = w_grant;
            if (w_accept) w_nextState = ISSUE;
         end
         ISSUE: begin
            fma_en      = 1'b1;
            w_nextState = WAIT;
         end
         WAIT: begin
            if (r_cnt == 4'd1) w_nextState = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // r_armed blocks acceptance in the cycle in which reset is released.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= '0;
         r_data  <= '0;
         r_rnd   <= '0;
         r_id    <= '0;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_armed <= 1'b1;
         if (w_accept) begin
            r_a   <= w_opA;
            r_b   <= w_selB;
            r_c   <= w_opC;
            r_rnd <= w_selRnd;
            r_id  <= 2'(w_winner);
            r_ptr <= (w_winner == IDXW'(NREQ-1)) ? '0 : w_winner + 1'b1;
         end
         if (r_state == ISSUE) begin
            r_cnt <= 4'(LAT);
         end else if (r_state == WAIT) begin
            if (r_cnt == 4'd1) r_data <= fma_result;
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   assign w_busy    = (r_state == ISSUE) || (r_state == WAIT);
   assign fma_a     = w_busy ? r_a   : '0;
   assign fma_b     = w_busy ? r_b   : '0;
   assign fma_c     = w_busy ? r_c   : '0;
   assign fma_rnd   = w_busy ? r_rnd : '0;
   assign resp_id   = resp_valid ? r_id   : '0;
   assign resp_data = resp_valid ? r_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_fma_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fma_sched : scoreboard bench with behavioural delayed a*b+c unit  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fma_sched;

   localparam int WIDTH = 32;
   localparam int NREQ  = 3;
   localparam int LAT   = 3;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]       reqValid;
   logic [NREQ-1:0]       reqReady;
   logic [NREQ*WIDTH-1:0] reqA, reqB, reqC;
   logic [NREQ*2-1:0]     reqOp, reqRnd;
   logic                  respValid, respReady;
   logic [1:0]            respId;
   logic [WIDTH-1:0]      respData;
   logic [WIDTH-1:0]      fmaA, fmaB, fmaC, fmaResult;
   logic [1:0]            fmaRnd;
   logic                  fmaEn;

   fma_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
      .clk        (clk),
      .RST        (rstN),
      .req_valid  (reqValid),
      .req_ready  (reqReady),
      .req_a      (reqA),
      .req_b      (reqB),
      .req_c      (reqC),
      .req_op     (reqOp),
      .req_rnd    (reqRnd),
      .resp_valid (respValid),
      .resp_ready (respReady),
      .resp_id    (respId),
      .resp_data  (respData),
      .fma_a      (fmaA),
      .fma_b      (fmaB),
      .fma_c      (fmaC),
      .fma_rnd    (fmaRnd),
      .fma_en     (fmaEn),
      .fma_result (fmaResult)
   );

   // Behavioural FMA: normal single-precision values only, result valid LAT cycles after fma_en.
   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) d = {f[31], 63'd0};
      else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   logic [31:0] pipeData [LAT];
   logic        pipeV    [LAT];
   always @(posedge clk) begin
      pipeData[0] <= r2f(f2r(fmaA) * f2r(fmaB) + f2r(fmaC));
      pipeV[0]    <= fmaEn;
      for (int i = 1; i < LAT; i++) begin
         pipeData[i] <= pipeData[i-1];
         pipeV[i]    <= pipeV[i-1];
      end
   end
   assign fmaResult = pipeV[LAT-1] ? pipeData[LAT-1] : 32'hDEADBEEF;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] data;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   nChecks = 0;
   int   nPass   = 0;
   int   nPopped = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      nChecks++;
      if (act === expv) nPass++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   always @(negedge clk) begin
      if (rstN && respValid && respReady) begin
         if (expQ.size() == 0) begin
            check("resp_unexpected", 64'd1, 64'd0);
         end else begin
            monE = expQ.pop_front();
            check("resp_id", 64'(respId), 64'(monE.id));
            check("resp_data", 64'(respData), 64'(monE.data));
         end
         nPopped++;
      end
   end

   task automatic checkIdleZero(input string tag);
      check({tag, "_ctrl"}, 64'({reqReady, respValid, respId, fmaRnd, fmaEn}), 64'd0);
      check({tag, "_data"}, 64'(respData | fmaA | fmaB | fmaC), 64'd0);
   endtask

   task automatic setReq(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [1:0] op);
      reqA[id*WIDTH +: WIDTH] = a;
      reqB[id*WIDTH +: WIDTH] = b;
      reqC[id*WIDTH +: WIDTH] = c;
      reqOp[id*2 +: 2]        = op;
      reqRnd[id*2 +: 2]       = 2'(id + 1);
      reqValid[id]            = 1'b1;
   endtask

   // Called at a negedge; returns just after the accepting posedge with valid dropped.
   task automatic waitAccept(input int id);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
         #1;
         if (reqReady[id] && reqValid[id]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check("accept_timeout", 64'd0, 64'd1);
      end else begin
         @(posedge clk);
         #1;
         reqValid[id] = 1'b0;
      end
   endtask

   task automatic runLatency(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [1:0] op,
                             input logic [31:0] expA, input logic [31:0] expC,
                             input logic [31:0] expData);
      int n, enCnt;
      expQ.push_back('{id: 2'(id), data: expData});
      setReq(id, a, b, c, op);
      waitAccept(id);
      n = 0;
      enCnt = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         n++;
         if (fmaEn) begin
            enCnt++;
            check("en_cycle", 64'(n), 64'd1);
            check("fma_a", 64'(fmaA), 64'(expA));
            check("fma_b", 64'(fmaB), 64'(b));
            check("fma_c", 64'(fmaC), 64'(expC));
            check("fma_rnd", 64'(fmaRnd), 64'(id + 1));
         end
         if (n == LAT + 1) check("hold_a_wait", 64'(fmaA), 64'(expA));
         if (respValid) break;
      end
      check("latency", 64'(n), 64'(LAT + 2));
      check("en_pulses", 64'(enCnt), 64'd1);
      @(negedge clk);
      checkIdleZero("idle_after");
   endtask

   task automatic waitPopped(input int target);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         #2;
         if (nPopped >= target) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("resp_timeout", 64'(nPopped), 64'(target));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reqValid  = '0;
      reqA      = '0;
      reqB      = '0;
      reqC      = '0;
      reqOp     = '0;
      reqRnd    = '0;
      respReady = 1'b1;
      repeat (3) @(negedge clk);
      checkIdleZero("reset");
      rstN = 1'b1;
      @(negedge clk);

      // Single-requester op mapping and latency
      runLatency(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00,
                 32'h3F800000, 32'h40400000, 32'h40A00000);
      runLatency(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b11,
                 32'hBF800000, 32'hC0400000, 32'hC0A00000);
      runLatency(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b01,
                 32'h3F800000, 32'hC0400000, 32'hBF800000);

      // All requesters continuously valid from reset release
      #1 rstN = 1'b0;
      @(negedge clk);
      checkIdleZero("rst_hold");
      setReq(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00);
      setReq(1, 32'h3F800000, 32'h40000000, 32'h3F800000, 2'b00);
      setReq(2, 32'h3F800000, 32'h40000000, 32'h40000000, 2'b00);
      for (int r = 0; r < 2; r++) begin
         expQ.push_back('{id: 2'd0, data: 32'h40A00000});
         expQ.push_back('{id: 2'd1, data: 32'h40400000});
         expQ.push_back('{id: 2'd2, data: 32'h40800000});
      end
      @(negedge clk);
      rstN = 1'b1;
      #1 check("ready_release_cycle", 64'(reqReady), 64'd0);
      @(posedge clk);
      #1 check("ready_after_release", 64'(reqReady), 64'b001);
      waitPopped(nPopped + 6);
      reqValid = '0;
      check("rr_queue_drained", 64'(expQ.size()), 64'd0);
      @(negedge clk);

      // Requester 1 withdraws while busy; 2 must win, then ptr wraps to 0
      expQ.push_back('{id: 2'd0, data: 32'h40A00000});
      expQ.push_back('{id: 2'd2, data: 32'h40800000});
      setReq(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00);
      waitAccept(0);
      setReq(1, 32'h3F800000, 32'h40000000, 32'h3F800000, 2'b00);
      setReq(2, 32'h3F800000, 32'h40000000, 32'h40000000, 2'b00);
      @(negedge clk);
      reqValid[1] = 1'b0;
      waitAccept(2);
      @(negedge clk);
      expQ.push_back('{id: 2'd0, data: 32'h40A00000});
      expQ.push_back('{id: 2'd1, data: 32'h40400000});
      setReq(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00);
      setReq(1, 32'h3F800000, 32'h40000000, 32'h3F800000, 2'b00);
      waitAccept(0);
      @(negedge clk);
      waitAccept(1);
      waitPopped(nPopped + 4 - (4 - expQ.size()));
      waitPopped(nPopped + 0);
      for (int t = 0; t < 40 && expQ.size() != 0; t++) @(negedge clk);
      check("wrap_queue_drained", 64'(expQ.size()), 64'd0);

      // Consumer stall: response held, no new grant, no new start
      respReady = 1'b0;
      expQ.push_back('{id: 2'd0, data: 32'hC0A00000});
      setReq(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b11);
      waitAccept(0);
      setReq(1, 32'h3F800000, 32'h40000000, 32'h3F800000, 2'b00);
      for (int t = 0; t < 20 && !respValid; t++) @(negedge clk);
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         check("stall_valid", 64'(respValid), 64'd1);
         check("stall_data", 64'(respData), 64'hC0A00000);
         check("stall_ready", 64'(reqReady), 64'd0);
         check("stall_en", 64'(fmaEn), 64'd0);
      end
      @(posedge clk);
      #1 respReady = 1'b1;
      expQ.push_back('{id: 2'd1, data: 32'h40400000});
      @(negedge clk);
      waitAccept(1);
      for (int t = 0; t < 40 && expQ.size() != 0; t++) @(negedge clk);
      check("stall_queue_drained", 64'(expQ.size()), 64'd0);
      @(negedge clk);

      // Reset in WAIT discards the operation
      expQ.push_back('{id: 2'd0, data: 32'h40A00000});
      setReq(0, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00);
      waitAccept(0);
      @(negedge clk);
      @(negedge clk);
      #1 rstN = 1'b0;
      #1 checkIdleZero("rst_mid");
      expQ.delete();
      @(negedge clk);
      rstN = 1'b1;
      for (int t = 0; t < LAT + 4; t++) begin
         @(negedge clk);
         check("no_stale_resp", 64'(respValid), 64'd0);
      end
      runLatency(2, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b10,
                 32'hBF800000, 32'h40400000, 32'h3F800000);

      check("final_queue_empty", 64'(expQ.size()), 64'd0);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
